// File: rtl/axa_undo_stack_pkg.sv
// Shared AXA undo-stack definitions: word/depth sizing, source-type and opcode codes,
// and the RAM write-port payload used between the stack top and its storage.
`timescale 1ns/1ps
package axa_undo_stack_pkg;

  localparam int unsigned WORD       = 16;
  localparam int unsigned UNDO_DEPTH = 16;
  localparam int unsigned UNDO_AW    = $clog2(UNDO_DEPTH);

  typedef logic [WORD-1:0]    word_t;
  typedef logic [UNDO_AW-1:0] ptr_t;
  typedef logic [UNDO_AW:0]   cnt_t;

  // Register-read source selector; SRC_UNDO reads the stack through rd_idx/rd_data
  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_PC   = 2'd2,
    SRC_UNDO = 2'd3
  } src_type_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BR   = 4'hA,
    OP_JMP  = 4'hB,
    OP_LAND = 4'hC
  } opcode_e;

  // ALU results that overwrite a destination register, so the old value is saved
  function automatic logic op_pushes_dest(opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_LD: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_pushes_pc(opcode_e op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  typedef struct packed {
    logic  we;
    ptr_t  addr;
    word_t data;
  } ram_wr_t;

endpackage

// File: rtl/axa_undo_stack_if.sv
// Push / pop / random-read bundle between the ALU, register-read and commit stages
// and the undo stack.
`timescale 1ns/1ps
interface axa_undo_stack_if;
  import axa_undo_stack_pkg::*;

  logic  push_dest_vld;
  word_t push_dest;
  logic  push_pc_vld;
  word_t push_pc;
  logic  pop_req;
  logic  pop_vld;
  word_t pop_data;
  ptr_t  rd_idx;
  word_t rd_data;
  cnt_t  count;
  logic  empty;
  logic  full;
  logic  overflow;
  logic  underflow;

  modport master (
    output push_dest_vld, push_dest, push_pc_vld, push_pc, pop_req, rd_idx,
    input  pop_vld, pop_data, rd_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push_dest_vld, push_dest, push_pc_vld, push_pc, pop_req, rd_idx,
    output pop_vld, pop_data, rd_data, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/axa_undo_ram.sv
// Undo-stack storage: two synchronous write ports (wr1 wins on a clash) and two
// asynchronous read ports. Contents are deliberately not reset.
`timescale 1ns/1ps
module axa_undo_ram
  import axa_undo_stack_pkg::*;
(
  input  logic    clk,
  input  ram_wr_t wr0,
  input  ram_wr_t wr1,
  input  ptr_t    ra0,
  output word_t   rd0,
  input  ptr_t    ra1,
  output word_t   rd1
);

  word_t mem [UNDO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr0.we) mem[wr0.addr] <= wr0.data;
    if (wr1.we) mem[wr1.addr] <= wr1.data;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/axa_undo_stack.sv
// Circular LIFO of pre-write dest values and return PCs; the oldest entry is
// overwritten when full. Registered pop port plus combinational offset-from-top read.
`timescale 1ns/1ps
module axa_undo_stack
  import axa_undo_stack_pkg::*;
(
  input logic             clk,
  input logic             reset,
  axa_undo_stack_if.slave bus
);

  ptr_t  top_q,      top_nxt;
  cnt_t  count_q,    count_nxt;
  logic  empty_q,    empty_nxt;
  logic  full_q,     full_nxt;
  logic  ovf_q,      ovf_nxt;
  logic  unf_q,      unf_nxt;
  logic  pop_vld_q,  pop_vld_nxt;
  word_t pop_data_q, pop_data_nxt;

  logic       pop_eff_c;
  logic [1:0] npush_c;
  ptr_t       base_c;
  cnt_t       sum_c;
  ram_wr_t    wr0_c, wr1_c;
  ptr_t       ra_rd_c, ra_pop_c;
  word_t      rd_mem_c, pop_mem_c;

  axa_undo_ram u_ram (
    .clk (clk),
    .wr0 (wr0_c),
    .wr1 (wr1_c),
    .ra0 (ra_rd_c),
    .rd0 (rd_mem_c),
    .ra1 (ra_pop_c),
    .rd1 (pop_mem_c)
  );

  // Pop resolves first against the pre-cycle state; pushes then build on the popped top
  always_comb begin
    pop_eff_c    = 1'b0;
    npush_c      = 2'd0;
    base_c       = top_q;
    sum_c        = count_q;
    wr0_c        = '0;
    wr1_c        = '0;
    ra_rd_c      = top_q - ptr_t'(1) - bus.rd_idx;
    ra_pop_c     = top_q - ptr_t'(1);
    top_nxt      = top_q;
    count_nxt    = count_q;
    empty_nxt    = empty_q;
    full_nxt     = full_q;
    ovf_nxt      = ovf_q;
    unf_nxt      = 1'b0;
    pop_vld_nxt  = bus.pop_req;
    pop_data_nxt = pop_data_q;

    pop_eff_c = bus.pop_req && (count_q != '0);
    npush_c   = {1'b0, bus.push_dest_vld} + {1'b0, bus.push_pc_vld};
    base_c    = pop_eff_c ? (top_q - ptr_t'(1)) : top_q;
    sum_c     = count_q - cnt_t'(pop_eff_c) + cnt_t'(npush_c);

    if (bus.pop_req) begin
      pop_data_nxt = pop_eff_c ? pop_mem_c : '0;
      unf_nxt      = !pop_eff_c;
    end

    // Dest always lands below pc when both push together
    wr0_c.we   = bus.push_dest_vld || bus.push_pc_vld;
    wr0_c.addr = base_c;
    wr0_c.data = bus.push_dest_vld ? bus.push_dest : bus.push_pc;
    wr1_c.we   = bus.push_dest_vld && bus.push_pc_vld;
    wr1_c.addr = base_c + ptr_t'(1);
    wr1_c.data = bus.push_pc;

    top_nxt = base_c + ptr_t'(npush_c);

    if (sum_c > cnt_t'(UNDO_DEPTH)) begin
      count_nxt = cnt_t'(UNDO_DEPTH);
      ovf_nxt   = 1'b1;
    end else begin
      count_nxt = sum_c;
    end

    empty_nxt = (count_nxt == '0);
    full_nxt  = (count_nxt == cnt_t'(UNDO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q      <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      pop_vld_q  <= 1'b0;
      pop_data_q <= '0;
    end else begin
      top_q      <= top_nxt;
      count_q    <= count_nxt;
      empty_q    <= empty_nxt;
      full_q     <= full_nxt;
      ovf_q      <= ovf_nxt;
      unf_q      <= unf_nxt;
      pop_vld_q  <= pop_vld_nxt;
      pop_data_q <= pop_data_nxt;
    end
  end

  // Entries at or beyond count are stale storage and read as zero
  assign bus.rd_data   = (cnt_t'(bus.rd_idx) < count_q) ? rd_mem_c : '0;
  assign bus.pop_vld   = pop_vld_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_axa_undo_stack.sv
// Bench for axa_undo_stack: directed scenarios plus a randomized run checked
// against a queue-based LIFO reference model.
`timescale 1ns/10ps
module tb_axa_undo_stack;
  import axa_undo_stack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axa_undo_stack_if bus ();

  axa_undo_stack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: newest entry at the back of the queue
  word_t mq[$];
  bit    m_ovf;
  bit    e_pop_vld;
  word_t e_pop_data;
  bit    e_unf;

  function automatic word_t m_rd(input int idx);
    if (idx < mq.size()) return mq[mq.size() - 1 - idx];
    return '0;
  endfunction

  task automatic m_push(input word_t v);
    mq.push_back(v);
    if (mq.size() > int'(UNDO_DEPTH)) begin
      void'(mq.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_step(input bit dv, input word_t d, input bit pv, input word_t p, input bit pop);
    e_pop_vld = pop;
    e_unf     = pop && (mq.size() == 0);
    if (pop) begin
      if (mq.size() > 0) e_pop_data = mq.pop_back();
      else               e_pop_data = '0;
    end
    if (dv) m_push(d);
    if (pv) m_push(p);
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf      = 1'b0;
    e_pop_vld  = 1'b0;
    e_pop_data = '0;
    e_unf      = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.push_dest_vld = 1'b0;
    bus.push_dest     = '0;
    bus.push_pc_vld   = 1'b0;
    bus.push_pc       = '0;
    bus.pop_req       = 1'b0;
    bus.rd_idx        = '0;
  endtask

  // Apply one cycle of requests; returns 1 ns after the capturing edge
  task automatic cycle(input bit dv, input word_t d, input bit pv, input word_t p, input bit pop);
    @(negedge clk);
    bus.push_dest_vld = dv;
    bus.push_dest     = d;
    bus.push_pc_vld   = pv;
    bus.push_pc       = p;
    bus.pop_req       = pop;
    @(posedge clk);
    #1;
    idle_inputs();
    model_step(dv, d, pv, p, pop);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    word_t got;
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b want=0", bus.full); end
    n_vec++; if (bus.pop_vld !== 1'b0) begin n_err++; $display("FAIL reset_pop_vld got=%b want=0", bus.pop_vld); end
    n_vec++; if (bus.pop_data !== 16'h0) begin n_err++; $display("FAIL reset_pop_data got=%h want=0000", bus.pop_data); end
    n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%b want=0", bus.underflow); end
    // Overflow the stack, then add a 3-value burst, then reset between edges
    for (int i = 1; i <= 17; i++) cycle(1'b1, word_t'(i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, word_t'(16'h0A00 + i), 1'b0, '0, 1'b0);
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL pre_reset_overflow got=%b want=1", bus.overflow); end
    @(negedge clk);
    #1 reset = 1'b1;
    #0.5;
    bus.rd_idx = '0;
    #0.1 got = bus.rd_data;
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL async_reset_count got=%0d want=0", bus.count); end
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL async_reset_empty got=%b want=1", bus.empty); end
    n_vec++; if (got !== 16'h0) begin n_err++; $display("FAIL async_reset_rd_data got=%h want=0000", got); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL async_reset_overflow got=%b want=0", bus.overflow); end
    #0.4 reset = 1'b0;
    model_clear();
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL post_reset_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_push_pop();
    do_reset();
    cycle(1'b1, 16'h1111, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 16'h2222, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    bus.rd_idx = 4'd0;
    #0.2;
    n_vec++; if (bus.pop_vld !== 1'b1) begin n_err++; $display("FAIL pp_pop_vld got=%b want=1", bus.pop_vld); end
    n_vec++; if (bus.pop_data !== 16'h2222) begin n_err++; $display("FAIL pp_pop_data got=%h want=2222", bus.pop_data); end
    n_vec++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL pp_count got=%0d want=1", bus.count); end
    n_vec++; if (bus.rd_data !== 16'h1111) begin n_err++; $display("FAIL pp_rd0 got=%h want=1111", bus.rd_data); end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (bus.pop_vld !== 1'b0) begin n_err++; $display("FAIL pp_pop_vld_pulse got=%b want=0", bus.pop_vld); end
  endtask

  task automatic test_dual_push();
    do_reset();
    cycle(1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0);
    n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL dual_count got=%0d want=2", bus.count); end
    bus.rd_idx = 4'd0; #0.2;
    n_vec++; if (bus.rd_data !== 16'hBBBB) begin n_err++; $display("FAIL dual_rd0 got=%h want=bbbb", bus.rd_data); end
    bus.rd_idx = 4'd1; #0.2;
    n_vec++; if (bus.rd_data !== 16'hAAAA) begin n_err++; $display("FAIL dual_rd1 got=%h want=aaaa", bus.rd_data); end
    bus.rd_idx = 4'd2; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0) begin n_err++; $display("FAIL dual_rd2 got=%h want=0000", bus.rd_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, word_t'(i), 1'b0, '0, 1'b0);
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full16 got=%b want=1", bus.full); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b want=0", bus.overflow); end
    cycle(1'b1, 16'h0011, 1'b0, '0, 1'b0);
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full got=%b want=1", bus.full); end
    n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_count got=%0d want=16", bus.count); end
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
    bus.rd_idx = 4'd15; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0002) begin n_err++; $display("FAIL ovf_rd15 got=%h want=0002", bus.rd_data); end
    bus.rd_idx = 4'd0; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0011) begin n_err++; $display("FAIL ovf_rd0 got=%h want=0011", bus.rd_data); end
    // Dual push one short of full also loses the oldest entry
    do_reset();
    for (int i = 1; i <= 15; i++) cycle(1'b1, word_t'(i), 1'b0, '0, 1'b0);
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL dual_ovf_early got=%b want=0", bus.overflow); end
    cycle(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL dual_ovf_flag got=%b want=1", bus.overflow); end
    n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL dual_ovf_count got=%0d want=16", bus.count); end
    bus.rd_idx = 4'd0; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0200) begin n_err++; $display("FAIL dual_ovf_rd0 got=%h want=0200", bus.rd_data); end
    bus.rd_idx = 4'd1; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0100) begin n_err++; $display("FAIL dual_ovf_rd1 got=%h want=0100", bus.rd_data); end
    bus.rd_idx = 4'd15; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0002) begin n_err++; $display("FAIL dual_ovf_rd15 got=%h want=0002", bus.rd_data); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b1, 16'h1234, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (bus.pop_data !== 16'h1234) begin n_err++; $display("FAIL unf_prepop got=%h want=1234", bus.pop_data); end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (bus.pop_vld !== 1'b1) begin n_err++; $display("FAIL unf_pop_vld got=%b want=1", bus.pop_vld); end
    n_vec++; if (bus.pop_data !== 16'h0) begin n_err++; $display("FAIL unf_pop_data got=%h want=0000", bus.pop_data); end
    n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL unf_flag got=%b want=1", bus.underflow); end
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL unf_count got=%0d want=0", bus.count); end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL unf_pulse got=%b want=0", bus.underflow); end
    cycle(1'b1, 16'h00EE, 1'b0, '0, 1'b0);
    bus.rd_idx = 4'd0; #0.2;
    n_vec++; if (bus.rd_data !== 16'h00EE) begin n_err++; $display("FAIL unf_top_intact got=%h want=00ee", bus.rd_data); end
  endtask

  task automatic test_pop_push();
    do_reset();
    cycle(1'b1, 16'h0005, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0006, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0007, 1'b0, '0, 1'b1);
    n_vec++; if (bus.pop_vld !== 1'b1) begin n_err++; $display("FAIL pop_push_vld got=%b want=1", bus.pop_vld); end
    n_vec++; if (bus.pop_data !== 16'h0006) begin n_err++; $display("FAIL pop_push_data got=%h want=0006", bus.pop_data); end
    n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL pop_push_count got=%0d want=2", bus.count); end
    bus.rd_idx = 4'd0; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0007) begin n_err++; $display("FAIL pop_push_rd0 got=%h want=0007", bus.rd_data); end
    bus.rd_idx = 4'd1; #0.2;
    n_vec++; if (bus.rd_data !== 16'h0005) begin n_err++; $display("FAIL pop_push_rd1 got=%h want=0005", bus.rd_data); end
  endtask

  task automatic test_random();
    bit    dv, pv, pop;
    word_t d, p;
    int    idx;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      dv  = ($urandom_range(0, 1) == 1);
      pv  = ($urandom_range(0, 3) == 0);
      pop = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d   = word_t'($urandom);
      p   = word_t'($urandom);
      cycle(dv, d, pv, p, pop);
      n_vec++; if (bus.pop_vld !== e_pop_vld) begin n_err++; $display("FAIL rnd_pop_vld n=%0d got=%b want=%b", n, bus.pop_vld, e_pop_vld); end
      if (e_pop_vld) begin
        n_vec++; if (bus.pop_data !== e_pop_data) begin n_err++; $display("FAIL rnd_pop_data n=%0d got=%h want=%h", n, bus.pop_data, e_pop_data); end
      end
      n_vec++; if (bus.underflow !== e_unf) begin n_err++; $display("FAIL rnd_underflow n=%0d got=%b want=%b", n, bus.underflow, e_unf); end
      n_vec++; if (bus.count !== cnt_t'(mq.size())) begin n_err++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.count, mq.size()); end
      n_vec++; if (bus.empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty n=%0d got=%b want=%b", n, bus.empty, mq.size() == 0); end
      n_vec++; if (bus.full !== (mq.size() == int'(UNDO_DEPTH))) begin n_err++; $display("FAIL rnd_full n=%0d got=%b size=%0d", n, bus.full, mq.size()); end
      n_vec++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow n=%0d got=%b want=%b", n, bus.overflow, m_ovf); end
      for (int k = 0; k < 2; k++) begin
        idx = (k == 0) ? 0 : int'($urandom_range(0, UNDO_DEPTH - 1));
        bus.rd_idx = ptr_t'(idx);
        #0.2;
        n_vec++; if (bus.rd_data !== m_rd(idx)) begin n_err++; $display("FAIL rnd_rd n=%0d idx=%0d got=%h want=%h", n, idx, bus.rd_data, m_rd(idx)); end
      end
      bus.rd_idx = '0;
      // Occasional asynchronous reset landing between clock edges
      if (n == 330) begin
        #0.5 reset = 1'b1;
        #1   reset = 1'b0;
        model_clear();
        n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rnd_async_reset_count got=%0d want=0", bus.count); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_push_pop();
    test_dual_push();
    test_overflow();
    test_underflow();
    test_pop_push();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
